// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and signed saturation bounds shared by alu_pipe_acc
package alu_pkg;
    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_MAC     = 3'd3;
    localparam logic [2:0] OP_MAX     = 3'd4;
    localparam logic [2:0] OP_MIN     = 3'd5;
    localparam logic [2:0] OP_ABSDIFF = 3'd6;
    localparam logic [2:0] OP_CLR     = 3'd7;
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/alu_exec.sv
// alu_exec: combinational opcode execute; MAC clamps when ALU_SAT_EN is defined, wraps otherwise
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2 * DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic [2:0]               inst,
    input  logic signed [OUT_W-1:0]  acc,
    output logic signed [OUT_W-1:0]  result,
    output logic signed [OUT_W-1:0]  acc_next,
    output logic                     ovf
);
    logic signed [OUT_W-1:0] ax, bx, diff, prod, mac_val;
    logic                    mac_ovf;
    assign ax   = {{(OUT_W-DATA_W){a[DATA_W-1]}}, a};
    assign bx   = {{(OUT_W-DATA_W){b[DATA_W-1]}}, b};
    assign diff = ax - bx;
    assign prod = ax * bx;
`ifdef ALU_SAT_EN
    logic signed [OUT_W:0] mac_sum;
    assign mac_sum = {acc[OUT_W-1], acc} + {prod[OUT_W-1], prod};
    assign mac_ovf = mac_sum[OUT_W] ^ mac_sum[OUT_W-1];
    assign mac_val = mac_ovf ? (mac_sum[OUT_W] ? OUT_W'(sat_min(OUT_W)) : OUT_W'(sat_max(OUT_W)))
                             : mac_sum[OUT_W-1:0];
`else
    assign mac_val = acc + prod;
    assign mac_ovf = 1'b0;
`endif
    // select the result for the opcode; only MAC and CLR touch the accumulator
    always_comb begin
        result   = inst == OP_ADD     ? ax + bx :
                   inst == OP_SUB     ? diff :
                   inst == OP_MUL     ? prod :
                   inst == OP_MAC     ? mac_val :
                   inst == OP_MAX     ? (ax > bx ? ax : bx) :
                   inst == OP_MIN     ? (ax < bx ? ax : bx) :
                   inst == OP_ABSDIFF ? (diff < 0 ? -diff : diff) : '0;
        acc_next = inst == OP_MAC ? mac_val : inst == OP_CLR ? '0 : acc;
        ovf      = inst == OP_MAC && mac_ovf;
    end
endmodule

// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: 2-stage valid/ready signed ALU with persistent accumulator (optional MAC saturation: ALU_SAT_EN)
module alu_pipe_acc
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2 * DATA_W
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_a_i,
    input  logic [DATA_W-1:0] data_b_i,
    input  logic [2:0]        inst_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              ovf_o
);
    logic [DATA_W-1:0] a1, b1;
    logic [2:0]        op1;
    logic              v1, adv2, ovf_nx;
    logic [OUT_W-1:0]  acc, res, acc_nx;
    assign adv2    = !valid_o || ready_i;
    assign ready_o = !v1 || adv2;
    alu_exec #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_exec (
        .a(a1), .b(b1), .inst(op1), .acc(acc),
        .result(res), .acc_next(acc_nx), .ovf(ovf_nx)
    );
    // S1: capture the operand beat whenever the stage can advance
    always_ff @(posedge clk_p_i or negedge reset_n_i)
        if (!reset_n_i) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            op1 <= OP_ADD;
        end else if (ready_o) begin
            v1  <= valid_i;
            a1  <= data_a_i;
            b1  <= data_b_i;
            op1 <= inst_i;
        end
    // S2: register the result and commit the accumulator; bubbles only clear valid_o
    always_ff @(posedge clk_p_i or negedge reset_n_i)
        if (!reset_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            ovf_o   <= 1'b0;
            acc     <= '0;
        end else if (adv2) begin
            valid_o <= v1;
            if (v1) begin
                data_o <= res;
                ovf_o  <= ovf_nx;
                acc    <= acc_nx;
            end
        end
endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb_alu_pipe_acc: randomized and directed checks of alu_pipe_acc against a queue-based reference model
module tb_alu_pipe_acc;
    logic        clk = 1'b0;
    logic        rst_n, valid_i, ready_i, ready_o, valid_o, ovf_o;
    logic [7:0]  a, b;
    logic [2:0]  op;
    logic [15:0] data_o;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [16:0] exp_q[$], got_q[$];
    int          stamp_q[$], lat_q[$];
    longint      m_acc = 0;

    alu_pipe_acc #(.DATA_W(8), .OUT_W(16)) dut (
        .clk_p_i(clk), .reset_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_a_i(a), .data_b_i(b), .inst_i(op), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        longint sa, sb, r;
        logic ov;
        logic [15:0] rl;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ov = 1'b0;
        r  = 0;
        case (o)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = sa * sb;
            3'd3: begin
                r = m_acc + sa * sb;
`ifdef ALU_SAT_EN
                if (r > 32767) begin r = 32767; ov = 1'b1; end
                else if (r < -32768) begin r = -32768; ov = 1'b1; end
`else
                r = ((r % 65536) + 65536) % 65536;
                if (r > 32767) r = r - 65536;
`endif
                m_acc = r;
            end
            3'd4: r = sa > sb ? sa : sb;
            3'd5: r = sa < sb ? sa : sb;
            3'd6: r = sa > sb ? sa - sb : sb - sa;
            default: begin r = 0; m_acc = 0; end
        endcase
        rl = r[15:0];
        return {ov, rl};
    endfunction

    task automatic tick();
        #1;
        if (valid_i && ready_o) begin
            exp_q.push_back(model(a, b, op));
            stamp_q.push_back(cyc);
        end
        if (valid_o && ready_i) begin
            got_q.push_back({ovf_o, data_o});
            lat_q.push_back(stamp_q.size() > 0 ? cyc - stamp_q.pop_front() : -1);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        valid_i = v;
        op = o;
        a = x;
        b = y;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
        tick();
        tick();
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        stamp_q.delete();
        lat_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        ready_i = 1'b1;
        #3;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid_o got %b need 0", valid_o); end
        n_cmp++; if (data_o !== 16'h0) begin n_bad++; $display("FAIL reset_data_o got %h need 0000", data_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_o got %b need 0", ovf_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_o got %b need 1", ready_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid_o got %b need 0", valid_o); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[10] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd7, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [7:0]  as[10]  = '{8'h00, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h03, 8'hFE, 8'h80, 8'h80, 8'h80};
        logic [7:0]  bs[10]  = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h00, 8'h04, 8'h05, 8'h7F, 8'h7F, 8'h7F};
        logic [15:0] lit[10] = '{16'h0000, 16'h0080, 16'hFFFF, 16'h4000, 16'h0000,
                                 16'h000C, 16'h0002, 16'h007F, 16'hFF80, 16'h00FF};
        clear_q();
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            tick();
        end
        drain();
        n_cmp++; if (got_q.size() != 10) begin n_bad++; $display("FAIL directed_count got %0d need 10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== {1'b0, lit[i]}) begin n_bad++; $display("FAIL directed_%0d got %h need %h", i, got_q[i], {1'b0, lit[i]}); end
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL directed_model_%0d got %h need %h", i, got_q[i], exp_q[i]); end
            n_cmp++; if (lat_q[i] != 2) begin n_bad++; $display("FAIL directed_latency_%0d got %0d need 2", i, lat_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] snap;
        clear_q();
        ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
            tick();
        end
        snap = data_o;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
            n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_ready_o_%0d got %b need 0", i, ready_o); end
            n_cmp++; if (valid_o !== 1'b1 || data_o !== snap) begin n_bad++; $display("FAIL stall_hold_%0d got %b/%h need 1/%h", i, valid_o, data_o, snap); end
            tick();
        end
        n_cmp++; if (exp_q.size() != 2) begin n_bad++; $display("FAIL stall_accepts got %0d need 2", exp_q.size()); end
        drain();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_count got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_result_%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        logic vi[15], vo[15];
        clear_q();
        ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(i % 3 == 0, 3'd3, 8'($urandom), 8'($urandom));
            vi[i] = valid_i;
            vo[i] = valid_o;
            tick();
        end
        drain();
        for (int i = 0; i < 15; i++) begin
            n_cmp++; if (vo[i] !== (i >= 2 ? vi[i-2] : 1'b0)) begin n_bad++; $display("FAIL gap_valid_%0d got %b need %b", i, vo[i], i >= 2 ? vi[i-2] : 1'b0); end
        end
        n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL gap_count got %0d need 5", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gap_result_%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sat();
`ifdef ALU_SAT_EN
        logic [16:0] lit[4] = '{17'h00000, 17'h03F01, 17'h07E02, 17'h17FFF};
`else
        logic [16:0] lit[4] = '{17'h00000, 17'h03F01, 17'h07E02, 17'h0BD03};
`endif
        clear_q();
        ready_i = 1'b1;
        drive(1'b1, 3'd7, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd3, 8'h7F, 8'h7F);
            tick();
        end
        drain();
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL sat_count got %0d need 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== lit[i]) begin n_bad++; $display("FAIL sat_%0d got %h need %h", i, got_q[i], lit[i]); end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
            ready_i = 1'($urandom_range(0, 9) < 7);
            tick();
        end
        drain();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_midreset();
        clear_q();
        ready_i = 1'b1;
        drive(1'b1, 3'd7, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd3, 8'h7F, 8'h7F);
            tick();
        end
        valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 16'h0 || ovf_o !== 1'b0) begin n_bad++; $display("FAIL midreset_out got %b/%h/%b need 0/0000/0", valid_o, data_o, ovf_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midreset_ready got %b need 1", ready_o); end
        #2;
        rst_n = 1'b1;
        clear_q();
        m_acc = 0;
        drive(1'b1, 3'd3, 8'h01, 8'h01);
        tick();
        drain();
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL midreset_count got %0d need 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 17'h00001) begin n_bad++; $display("FAIL midreset_mac got %h need 00001", got_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_gaps();
        test_sat();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
